// File: rtl/car_lane_renderer.sv
// car_lane_renderer: draws periodic cars in stacked horizontal lanes. The
// scroll offset is latched once per frame and reduced modulo the car spacing
// by a small subtract-loop FSM. A per-pixel phase counter replaces any divider
// in the pixel path.
// Optional build macro CAR_LANE_TINT_EN: XORs the lane index into the top
// colour bits so each lane gets a different car colour.
module car_lane_renderer #(
    parameter int unsigned SCREEN_WIDTH = 640,
    parameter int unsigned CAR_SPACING  = 160,
    parameter int unsigned CAR_W        = 48,
    parameter int unsigned LANE_TOP     = 160,
    parameter int unsigned LANE_SHIFT   = 5,
    parameter int unsigned NUM_LANES    = 4,
    parameter logic [5:0]  CAR_COLOR    = 6'b110000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] h_pos,
    input  logic       frame_start,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       video_active,
    output logic       car_px,
    output logic [5:0] rgb
);

    localparam logic [9:0] Spacing  = 10'(CAR_SPACING);
    localparam logic [9:0] CarW     = 10'(CAR_W);
    localparam logic [9:0] LaneTop  = 10'(LANE_TOP);
    localparam logic [9:0] LaneEnd  = 10'(LANE_TOP + (NUM_LANES << LANE_SHIFT));
`ifdef CAR_LANE_TINT_EN
    localparam int unsigned LaneBits = 2;
`else
    localparam int unsigned LaneBits = 1;
`endif

    // Elaboration-time guard on the configuration.
    if ((SCREEN_WIDTH % CAR_SPACING) != 0 || CAR_W >= CAR_SPACING) begin : g_bad_cfg
        $error("car_lane_renderer: invalid SCREEN_WIDTH/CAR_SPACING/CAR_W");
    end

    typedef enum logic [0:0] {StIdle, StReduce} state_e;

    state_e             r_state;
    logic   [9:0]       r_acc;
    logic   [9:0]       r_rem;
    logic   [9:0]       r_seg_ctr;

    logic   [9:0]       w_dy;
    logic   [LaneBits-1:0] w_lane;
    logic               w_in_lane;
    logic               w_dir_right;
    logic   [9:0]       w_init;
    logic   [9:0]       w_phase;
    logic   [9:0]       w_phase_nxt;
    logic               w_hit;
    logic   [5:0]       w_color;

    // Offset FSM: latch h_pos on frame_start, then subtract until below spacing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_acc   <= 10'd0;
            r_rem   <= 10'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (frame_start) begin
                        r_acc   <= h_pos;
                        r_state <= StReduce;
                    end
                end
                StReduce: begin
                    if (frame_start) begin
                        // A new frame restarts the reduction with the fresh offset.
                        r_acc <= h_pos;
                    end else if (r_acc >= Spacing) begin
                        r_acc <= r_acc - Spacing;
                    end else begin
                        r_rem   <= r_acc;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Lane decode, phase selection and colour.
    always_comb begin
        w_dy        = pix_y - LaneTop;
        w_lane      = LaneBits'(w_dy >> LANE_SHIFT);
        w_in_lane   = (pix_y >= LaneTop) && (pix_y < LaneEnd);
        w_dir_right = ~w_lane[0];
        if (w_dir_right) begin
            w_init = (r_rem == 10'd0) ? 10'd0 : Spacing - r_rem;
        end else begin
            w_init = r_rem;
        end
        w_phase     = (pix_x == 10'd0) ? w_init : r_seg_ctr;
        w_phase_nxt = (w_phase == Spacing - 10'd1) ? 10'd0 : w_phase + 10'd1;
        w_hit       = video_active && w_in_lane && (w_phase < CarW);
`ifdef CAR_LANE_TINT_EN
        w_color     = CAR_COLOR ^ {w_lane[1:0], 4'b0000};
`else
        w_color     = CAR_COLOR;
`endif
    end

    // Phase counter advances only on active pixels; outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg_ctr <= 10'd0;
            car_px    <= 1'b0;
            rgb       <= 6'd0;
        end else begin
            if (video_active) begin
                r_seg_ctr <= w_phase_nxt;
            end
            car_px <= w_hit;
            rgb    <= w_hit ? w_color : 6'd0;
        end
    end

endmodule

// File: tb/tb_car_lane_renderer.sv
// Directed testbench for car_lane_renderer; works in both tint builds.
module tb_car_lane_renderer;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] h_pos;
    logic       frame_start;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       video_active;
    logic       car_px;
    logic [5:0] rgb;

    int total = 0;
    int bad   = 0;

    car_lane_renderer dut (
        .clk          (clk),
        .reset        (reset),
        .h_pos        (h_pos),
        .frame_start  (frame_start),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .video_active (video_active),
        .car_px       (car_px),
        .rgb          (rgb)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] lane_color(input int lane);
        logic [5:0] c;
        logic [1:0] l;
        c = 6'b110000;
        l = 2'(lane);
`ifdef CAR_LANE_TINT_EN
        c = c ^ {l, 4'b0000};
`endif
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse frame_start with offset h, then idle for wait_clks cycles.
    task automatic do_frame(input int h, input int wait_clks);
        h_pos       = 10'(h);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (wait_clks) tick();
    endtask

    // Scan one line; first<0 means no cars expected. Cars start at first+160k.
    task automatic scan_line(input string name, input int y, input bit va,
                             input int first, input int lane);
        int errs;
        int first_bad;
        logic       exp_px;
        logic [5:0] exp_rgb;
        logic       got_px;
        logic [5:0] got_rgb;
        errs = 0;
        first_bad = -1;
        got_px = 1'b0;
        got_rgb = 6'd0;
        pix_y = 10'(y);
        video_active = va;
        for (int x = 0; x < 640; x++) begin
            pix_x = 10'(x);
            tick();
            exp_px  = (first >= 0) && (((x - first + 640) % 160) < 48);
            exp_rgb = exp_px ? lane_color(lane) : 6'd0;
            if (car_px !== exp_px || rgb !== exp_rgb) begin
                if (errs == 0) begin
                    first_bad = x;
                    got_px = car_px;
                    got_rgb = rgb;
                end
                errs++;
            end
        end
        video_active = 1'b0;
        repeat (4) tick();
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL %s: %0d bad pixels, first x=%0d car_px=%b rgb=%b", name, errs,
                     first_bad, got_px, got_rgb);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pix_y = 10'd160;
        pix_x = 10'd0;
        video_active = 1'b1;
        for (int i = 0; i < 3; i++) begin
            h_pos = 10'd300;
            frame_start = (i != 1);
            pix_x = 10'(i);
            tick();
            total++;
            if (car_px !== 1'b0 || rgb !== 6'd0) begin
                bad++;
                $display("FAIL reset_out[%0d]: car_px=%b rgb=%b want 0", i, car_px, rgb);
            end
        end
        frame_start = 1'b0;
        video_active = 1'b0;
        reset = 1'b0;
        tick();
        total++;
        if (car_px !== 1'b0 || rgb !== 6'd0) begin
            bad++;
            $display("FAIL reset_release: car_px=%b rgb=%b want 0", car_px, rgb);
        end
        // No frame_start since reset: offset must be 0.
        scan_line("reset_offset0_lane0", 160, 1'b1, 0, 0);
    endtask

    task automatic test_offset_zero();
        do_frame(0, 8);
        scan_line("h0_lane0", 160, 1'b1, 0, 0);
        scan_line("h0_lane2", 224, 1'b1, 0, 2);
    endtask

    task automatic test_offset_20();
        do_frame(20, 8);
        scan_line("h20_lane0", 160, 1'b1, 20, 0);
        scan_line("h20_lane1", 192, 1'b1, 140, 1);
        scan_line("h20_lane3_bottom", 287, 1'b1, 140, 3);
    endtask

    task automatic test_latch_per_frame();
        do_frame(470, 5);
        // r=150: lane0 starts at 150, lane1 at 10.
        h_pos = 10'd100;
        scan_line("h470_lane0", 160, 1'b1, 150, 0);
        scan_line("h470_lane0_hchg", 170, 1'b1, 150, 0);
        scan_line("h470_lane1", 200, 1'b1, 10, 1);
    endtask

    task automatic test_restart_and_reset();
        h_pos = 10'd630;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        h_pos = 10'd2;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (6) tick();
        scan_line("restart_r2_lane0", 160, 1'b1, 2, 0);
        scan_line("restart_r2_lane1", 192, 1'b1, 158, 1);

        h_pos = 10'd630;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (6) tick();
        scan_line("midreset_lane0", 160, 1'b1, 0, 0);
        scan_line("midreset_lane3", 256, 1'b1, 0, 3);
    endtask

    task automatic test_out_of_range();
        do_frame(1000, 10);
        // 1000 mod 160 = 40: lane0 starts at 40, lane1 at 120.
        scan_line("h1000_lane0", 160, 1'b1, 40, 0);
        scan_line("h1000_lane1", 192, 1'b1, 120, 1);
    endtask

    task automatic test_boundaries();
        do_frame(0, 8);
        scan_line("y159_above", 159, 1'b1, -1, 0);
        scan_line("y288_below", 288, 1'b1, -1, 0);
        scan_line("inactive_in_lane", 160, 1'b0, -1, 0);
        scan_line("after_inactive", 160, 1'b1, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        h_pos = 10'd0;
        frame_start = 1'b0;
        pix_x = 10'd0;
        pix_y = 10'd0;
        video_active = 1'b0;
        test_reset();
        test_offset_zero();
        test_offset_20();
        test_latch_per_frame();
        test_restart_and_reset();
        test_out_of_range();
        test_boundaries();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
